johnson_step_sequencer: RTL and testbench

Command-driven controller for a WIDTH-stage Johnson phase generator, used for multi-phase drives such as stepper coils or phased strobes. The host issues a move command with a step count, direction and rate divider. The block advances the Johnson ring once per divided tick until the count is exhausted, and supports hold, abort and illegal-code recovery. It sits between a host/register interface and the phase-driven load.

---
 rtl/johnson_step_sequencer_pkg.sv | 63 ++++++
 rtl/johnson_step_core.sv | 65 ++++++
 rtl/johnson_step_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_johnson_step_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_step_sequencer_pkg.sv
//------------------------------------------------------------------------------
// johnson_seq_pkg
//
// Shared definitions for the Johnson step sequencer:
//   seq_state_t        - controller state encoding (IDLE/RUN/HOLD/FINISH)
//   DIR_FWD / DIR_REV  - values of the direction bit
//   JS_MAX_W / js_code_t - widest ring the helper functions can inspect
//   is_legal_johnson() - true when a code is one of the 2*width ring states
//   johnson_to_idx()   - forward-order position of a legal code (0 if illegal)
//
// The helpers take a zero-extended js_code_t plus the real ring width, so one
// copy serves every WIDTH the sequencer may be built with (WIDTH <= JS_MAX_W).
//------------------------------------------------------------------------------
package johnson_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_t;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    localparam int JS_MAX_W = 32;
    typedef logic [JS_MAX_W-1:0] js_code_t;

    // A Johnson ring only ever holds runs of the form 0..01..1 or 1..10..0,
    // so a code is legal exactly when it has at most one transition between
    // adjacent bits inside the ring width.
    function automatic logic is_legal_johnson(input js_code_t code, input int width);
        int edges;
        edges = 0;
        for (int i = 1; i < JS_MAX_W; i++) begin
            if (i < width && code[i] != code[i-1]) begin
                edges++;
            end
        end
        return (edges <= 1);
    endfunction

    // Forward-order index: all-zero is 0, trailing-ones codes sit at
    // 1..width (index = number of ones), leading-ones codes at
    // width+1..2*width-1 (index = 2*width - number of ones).
    function automatic int johnson_to_idx(input js_code_t code, input int width);
        int ones;
        ones = 0;
        for (int i = 0; i < JS_MAX_W; i++) begin
            if (i < width && code[i]) begin
                ones++;
            end
        end
        if (!is_legal_johnson(code, width)) begin
            return 0;
        end
        if (code[0] || ones == 0) begin
            return ones;
        end
        return 2 * width - ones;
    endfunction

endpackage

// File: rtl/johnson_step_core.sv
//------------------------------------------------------------------------------
// johnson_step_core
//
// The Johnson ring register itself. Each clock with step_en high the ring
// advances one position in the direction given by dir. A corrupted ring
// (any code outside the 2*WIDTH legal states) is reloaded with all-zero on
// the step instead, and phase_err pulses for the following cycle.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (ring -> all-zero)
//   step_en    in   advance the ring this edge
//   dir        in   DIR_FWD shifts ones in from bit 0, DIR_REV from the MSB
//   phase      out  registered ring state [WIDTH-1:0]
//   phase_err  out  one-cycle pulse after an illegal code was corrected
//------------------------------------------------------------------------------
module johnson_step_core
    import johnson_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_en,
    input  logic             dir,
    output logic [WIDTH-1:0] phase,
    output logic             phase_err
);

    logic [WIDTH-1:0] phase_q;
    logic [WIDTH-1:0] phase_next;
    logic             legal;

    always_comb begin
        legal      = is_legal_johnson(js_code_t'(phase_q), WIDTH);
        phase_next = phase_q;
        case (dir)
            DIR_FWD: phase_next = {phase_q[WIDTH-2:0], ~phase_q[WIDTH-1]};
            DIR_REV: phase_next = {~phase_q[0], phase_q[WIDTH-1:1]};
            default: phase_next = phase_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= '0;
            phase_err <= 1'b0;
        end else begin
            phase_err <= 1'b0;
            if (step_en) begin
                if (legal) begin
                    phase_q <= phase_next;
                end else begin
                    // Recovery still consumes the step; the host sees one
                    // fewer real phase advance and a phase_err pulse.
                    phase_q   <= '0;
                    phase_err <= 1'b1;
                end
            end
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/johnson_step_sequencer.sv
//------------------------------------------------------------------------------
// johnson_step_sequencer
//
// Command-driven controller for a WIDTH-stage Johnson phase generator. The
// host offers a move (step count, direction, clocks-per-step); the block
// advances the ring once per divided tick until the count is used up, with
// hold (freeze the divider), abort (stop now, keep position and remaining
// count) and illegal-code recovery handled by the ring core.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   cmd_valid    command offered (taken only while cmd_ready)
//   cmd_ready    high in IDLE
//   cmd_steps    steps to perform (0 completes immediately)
//   cmd_dir      1 = forward, 0 = reverse
//   cmd_div      clocks per step (0 behaves as 1)
//   hold         freeze stepping while high (RUN/HOLD only)
//   abort        end the current command (RUN/HOLD only, beats hold/tick)
//   phase        registered Johnson outputs
//   state_idx    decoded ring position, combinational from phase
//   steps_left   registered remaining step count
//   busy         high in RUN or HOLD
//   done         one-cycle completion pulse (FINISH state)
//   aborted      qualifies done; held until the next accepted command
//   phase_err    one-cycle pulse after an illegal phase code was corrected
//
// Timing: with the accept on edge T, step k lands on edge T + k*div, and
// each clock with hold high pushes every later step out by one clock.
//------------------------------------------------------------------------------
module johnson_step_sequencer
    import johnson_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [CNT_W-1:0]              cmd_steps,
    input  logic                          cmd_dir,
    input  logic [DIV_W-1:0]              cmd_div,
    input  logic                          hold,
    input  logic                          abort,
    output logic [WIDTH-1:0]              phase,
    output logic [$clog2(2*WIDTH)-1:0]    state_idx,
    output logic [CNT_W-1:0]              steps_left,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    output logic                          phase_err
);

    localparam int IDX_W = $clog2(2*WIDTH);

    seq_state_t       state;
    seq_state_t       state_next;

    logic [DIV_W-1:0] div_q;      // latched clocks-per-step, never zero
    logic [DIV_W-1:0] div_cnt;    // position inside the current step period
    logic             dir_q;
    logic             aborted_q;

    logic             accept;
    logic             active;
    logic             run_count;  // divider advances this edge
    logic             tick;       // divider is at its last count
    logic             step_en;
    logic             set_abort;

    //--------------------------------------------------------------------------
    // Ring core
    //--------------------------------------------------------------------------
    johnson_step_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .step_en   (step_en),
        .dir       (dir_q),
        .phase     (phase),
        .phase_err (phase_err)
    );

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    // NOTE: reset is synchronous, so rst is only looked at on the clock edge
    // and it is the first branch, which lets it win over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and control decode
    //--------------------------------------------------------------------------
    assign tick = (div_cnt == div_q - DIV_W'(1));

    // NOTE: every signal written here gets a default before the case, so no
    // path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        active     = 1'b0;
        run_count  = 1'b0;
        step_en    = 1'b0;
        set_abort  = 1'b0;

        case (state)
            ST_IDLE: begin
                // hold and abort have no meaning without a command.
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = (cmd_steps == '0) ? ST_FINISH : ST_RUN;
                end
            end

            // RUN and HOLD share one decode: a clock with hold low counts
            // even on the way out of HOLD, so a hold of N clocks delays the
            // rest of the move by exactly N clocks.
            ST_RUN, ST_HOLD: begin
                active = 1'b1;
                if (abort) begin
                    set_abort  = 1'b1;
                    state_next = ST_FINISH;
                end else if (hold) begin
                    state_next = ST_HOLD;
                end else begin
                    run_count  = 1'b1;
                    state_next = ST_RUN;
                    if (tick) begin
                        step_en = 1'b1;
                        if (steps_left == CNT_W'(1)) begin
                            state_next = ST_FINISH;
                        end
                    end
                end
            end

            ST_FINISH: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Divider, step counter and command latches
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            steps_left <= '0;
            div_q      <= DIV_W'(1);
            div_cnt    <= '0;
            dir_q      <= DIR_FWD;
            aborted_q  <= 1'b0;
        end else begin
            if (accept) begin
                steps_left <= cmd_steps;
                div_q      <= (cmd_div == '0) ? DIV_W'(1) : cmd_div;
                div_cnt    <= '0;
                dir_q      <= cmd_dir;
                aborted_q  <= 1'b0;
            end else if (run_count) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            end

            // accept and step_en come from different states, so they never
            // collide on steps_left.
            if (step_en) begin
                steps_left <= steps_left - CNT_W'(1);
            end

            if (set_abort) begin
                aborted_q <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = active;
    assign done      = (state == ST_FINISH);
    assign aborted   = aborted_q;
    assign state_idx = IDX_W'(johnson_to_idx(js_code_t'(phase), WIDTH));

endmodule

// File: tb/tb_johnson_step_sequencer.sv
//------------------------------------------------------------------------------
// tb_johnson_step_sequencer
//
// Directed and randomized commands against a position-based reference: the
// ring is tracked as an integer position 0..2W-1, and the number of steps
// taken by any edge is derived from elapsed un-held clocks divided by the
// rate, so the expected outputs come from arithmetic rather than registers.
//------------------------------------------------------------------------------
module tb_johnson_step_sequencer;

    localparam int W  = 4;
    localparam int CW = 16;
    localparam int DW = 16;
    localparam int NS = 2 * W;
    localparam int IW = $clog2(NS);

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_steps;
    logic          cmd_dir;
    logic [DW-1:0] cmd_div;
    logic          hold;
    logic          abort;
    logic [W-1:0]  phase;
    logic [IW-1:0] state_idx;
    logic [CW-1:0] steps_left;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          phase_err;

    int n_cmp;
    int n_err;
    int m_idx;      // model ring position

    johnson_step_sequencer #(
        .WIDTH (W),
        .CNT_W (CW),
        .DIV_W (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .cmd_div    (cmd_div),
        .hold       (hold),
        .abort      (abort),
        .phase      (phase),
        .state_idx  (state_idx),
        .steps_left (steps_left),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .phase_err  (phase_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no end of test, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ring code at forward position idx: trailing ones up to W, then the
    // ones drain out from the bottom.
    function automatic logic [W-1:0] idx2phase(input int idx);
        int v;
        if (idx <= W) v = (1 << idx) - 1;
        else          v = ((1 << W) - 1) ^ ((1 << (idx - W)) - 1);
        return W'(v);
    endfunction

    // Clocks since the accept edge that were not held.
    function automatic int eff(input int j, input int hs, input int hl);
        int held;
        held = 0;
        for (int k = 1; k <= j; k++) begin
            if (k >= hs && k < hs + hl) held++;
        end
        return j - held;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One command from accept until one clock after done. hs/hl: first edge
    // and length of a hold window (hl=0: none). ab: abort edge (0: none).
    task automatic run_cmd(input int n, input bit d, input int dv,
                           input int hs, input int hl, input int ab, input string name);
        int deff;
        int idx0;
        int endj;
        int s;
        int e_idx;
        deff = (dv == 0) ? 1 : dv;
        idx0 = m_idx;
        if (n == 0)      endj = 0;
        else if (ab > 0) endj = ab;
        else begin
            endj = 0;
            while (eff(endj, hs, hl) < n * deff) endj++;
        end

        check({name, ".ready_pre"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_steps = CW'(n);
        cmd_dir   = d;
        cmd_div   = DW'(dv);
        hold      = 1'b0;
        abort     = 1'b0;
        e_idx     = idx0;

        for (int j = 0; j <= endj + 1; j++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            cmd_steps = CW'($urandom);
            if (n == 0)                 s = 0;
            else if (ab > 0 && j >= ab) s = min2(eff(ab - 1, hs, hl) / deff, n);
            else                        s = min2(eff(j, hs, hl) / deff, n);
            e_idx = (((idx0 + (d ? s : -s)) % NS) + NS) % NS;

            check({name, ".phase"},      32'(phase),      32'(idx2phase(e_idx)));
            check({name, ".state_idx"},  32'(state_idx),  32'(e_idx));
            check({name, ".steps_left"}, 32'(steps_left), 32'(n - s));
            check({name, ".busy"},       32'(busy),       32'(j < endj));
            check({name, ".done"},       32'(done),       32'(j == endj));
            check({name, ".cmd_ready"},  32'(cmd_ready),  32'(j > endj));
            check({name, ".phase_err"},  32'(phase_err),  32'd0);
            if (j >= endj) check({name, ".aborted"}, 32'(aborted), 32'(ab > 0));

            hold  = (j + 1 >= hs) && (j + 1 < hs + hl);
            abort = (ab > 0) && (j + 1 == ab);
        end
        hold  = 1'b0;
        abort = 1'b0;
        m_idx = e_idx;
    endtask

    initial begin
        int n;
        int dv;
        int hs;
        int hl;
        int ab;
        bit d;

        n_cmp     = 0;
        n_err     = 0;
        m_idx     = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_steps = '0;
        cmd_dir   = 1'b0;
        cmd_div   = '0;
        hold      = 1'b0;
        abort     = 1'b0;

        // Reset, with command inputs active to show rst wins.
        repeat (2) @(posedge clk);
        cmd_valid = 1'b1;
        cmd_steps = CW'(5);
        @(posedge clk);
        #1;
        check("rst.phase",      32'(phase),      32'd0);
        check("rst.steps_left", 32'(steps_left), 32'd0);
        check("rst.busy",       32'(busy),       32'd0);
        check("rst.done",       32'(done),       32'd0);
        check("rst.aborted",    32'(aborted),    32'd0);
        check("rst.phase_err",  32'(phase_err),  32'd0);
        check("rst.state_idx",  32'(state_idx),  32'd0);
        cmd_valid = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        check("rst.cmd_ready",  32'(cmd_ready),  32'd1);
        check("rst.idle_busy",  32'(busy),       32'd0);

        // Directed sequence from the plan.
        run_cmd(3,   1'b1, 2, 0, 0, 0, "fwd3_div2");
        check("fwd3.final_phase", 32'(phase), 32'h7);
        run_cmd(9,   1'b0, 1, 0, 0, 0, "rev9_div1");
        check("rev9.final_phase", 32'(phase), 32'h3);
        run_cmd(10,  1'b1, 4, 9, 7, 0, "hold7");
        run_cmd(100, 1'b1, 1, 0, 0, 6, "abort");
        check("abort.left95", 32'(steps_left), 32'd95);
        run_cmd(0,   1'b1, 3, 0, 0, 0, "zero_steps");
        run_cmd(2,   1'b0, 0, 0, 0, 0, "div0");

        // Randomized commands, some with a hold window or an abort.
        for (int t = 0; t < 24; t++) begin
            n  = $urandom_range(0, 7);
            d  = 1'($urandom_range(0, 1));
            dv = $urandom_range(0, 3);
            hs = 0;
            hl = 0;
            ab = 0;
            if (n > 0 && $urandom_range(0, 2) == 0) begin
                hs = $urandom_range(1, n * ((dv == 0) ? 1 : dv));
                hl = $urandom_range(1, 5);
            end
            if (n > 0 && $urandom_range(0, 3) == 0) begin
                ab = $urandom_range(1, n * ((dv == 0) ? 1 : dv));
            end
            run_cmd(n, d, dv, hs, hl, ab, "rand");
        end

        // Illegal ring code recovery.
        @(negedge clk);
        force dut.u_core.phase_q = 4'b0101;
        @(posedge clk);
        #1;
        release dut.u_core.phase_q;
        check("ill.phase_pre",  32'(phase),     32'h5);
        check("ill.idx_pre",    32'(state_idx), 32'd0);
        cmd_valid = 1'b1;
        cmd_steps = CW'(2);
        cmd_dir   = 1'b1;
        cmd_div   = DW'(1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("ill.phase_acc",  32'(phase),     32'h5);
        @(posedge clk);
        #1;
        check("ill.phase_s1",   32'(phase),     32'h0);
        check("ill.err_s1",     32'(phase_err), 32'd1);
        check("ill.left_s1",    32'(steps_left), 32'd1);
        @(posedge clk);
        #1;
        check("ill.phase_s2",   32'(phase),     32'h1);
        check("ill.err_s2",     32'(phase_err), 32'd0);
        check("ill.done",       32'(done),      32'd1);
        check("ill.aborted",    32'(aborted),   32'd0);
        @(posedge clk);
        #1;
        check("ill.ready",      32'(cmd_ready), 32'd1);
        m_idx = 1;
        run_cmd(3, 1'b1, 1, 0, 0, 0, "post_ill");

        // Reset in the middle of a command: no done pulse, reset values.
        cmd_valid = 1'b1;
        cmd_steps = CW'(5);
        cmd_dir   = 1'b1;
        cmd_div   = DW'(2);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst.phase",      32'(phase),      32'd0);
        check("midrst.steps_left", 32'(steps_left), 32'd0);
        check("midrst.busy",       32'(busy),       32'd0);
        check("midrst.done",       32'(done),       32'd0);
        check("midrst.ready",      32'(cmd_ready),  32'd1);
        @(posedge clk);
        #1;
        check("midrst.done_after", 32'(done),       32'd0);
        m_idx = 0;
        run_cmd(2, 1'b0, 1, 0, 0, 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
